// File: rtl/booth_seq_mul_ctrl_if.sv
// Operand/product handshake bundle for booth_seq_mul_ctrl.
// master = producer/consumer side, slave = multiplier controller.
interface booth_seq_mul_ctrl_if #(
  parameter int N = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   M;
  logic [N-1:0]   R;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] P;

  modport master (
    output in_valid, M, R, out_ready,
    input  in_ready, out_valid, P
  );

  modport slave (
    input  in_valid, M, R, out_ready,
    output in_ready, out_valid, P
  );
endinterface

// File: rtl/booth_seq_mul_ctrl.sv
// Iterative radix-2 Booth multiplier: one partial product per clock, 2N-bit signed result.
// Optional early termination when BOOTH_EARLY_TERM_EN is defined.
module booth_seq_mul_ctrl #(
  parameter int N = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  booth_seq_mul_ctrl_if.slave bus,
  output logic                busy,
  output logic [1:0]          pp_sel
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_n;
  logic signed [N:0]     a, a_n;
  logic signed [N:0]     mreg, mreg_n;
  logic [N-1:0]          q, q_n;
  logic                  qm1, qm1_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [2*N-1:0]        p, p_n;

  // Result of one Booth step (add/sub then shift) on the current registers
  logic signed [N:0]     sum;
  logic signed [N:0]     a_s;
  logic [N-1:0]          q_s;
  logic                  qm1_s;
  logic [CW-1:0]         cnt_s;

`ifdef BOOTH_EARLY_TERM_EN
  localparam logic [N-1:0] ONES = '1;
  logic [N-1:0]          mask;
  logic                  early;
  logic [2*N-1:0]        p_early;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a     <= '0;
      mreg  <= '0;
      q     <= '0;
      qm1   <= 1'b0;
      cnt   <= '0;
      p     <= '0;
    end else begin
      state <= state_n;
      a     <= a_n;
      mreg  <= mreg_n;
      q     <= q_n;
      qm1   <= qm1_n;
      cnt   <= cnt_n;
      p     <= p_n;
    end
  end

  always_comb begin
    state_n = state;
    a_n     = a;
    mreg_n  = mreg;
    q_n     = q;
    qm1_n   = qm1;
    cnt_n   = cnt;
    p_n     = p;

    unique case ({q[0], qm1})
      2'b01:   sum = a + mreg;
      2'b10:   sum = a - mreg;
      default: sum = a;
    endcase
    a_s   = {sum[N], sum[N:1]};
    q_s   = {sum[0], q[N-1:1]};
    qm1_s = q[0];
    cnt_s = cnt + 1'b1;

`ifdef BOOTH_EARLY_TERM_EN
    // Checking the post-step remainder is equivalent to the pre-step check
    // (a uniform remainder decodes to zero) but also retires one edge sooner.
    mask    = ONES >> cnt_s;
    early   = qm1_s ? ((q_s & mask) == mask) : ((q_s & mask) == '0);
    p_early = (2*N)'($signed({a_s, q_s}) >>> (CW'(N) - cnt_s));
`endif

    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          a_n     = '0;
          q_n     = bus.R;
          qm1_n   = 1'b0;
          mreg_n  = {bus.M[N-1], bus.M};
          cnt_n   = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        a_n   = a_s;
        q_n   = q_s;
        qm1_n = qm1_s;
        cnt_n = cnt_s;
        if (cnt_s == CW'(N)) begin
          p_n     = {a_s[N-1:0], q_s};
          state_n = DONE;
        end
`ifdef BOOTH_EARLY_TERM_EN
        else if (early) begin
          p_n     = p_early;
          state_n = DONE;
        end
`endif
      end
      DONE: begin
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.P         = p;
  assign busy          = (state == RUN);

  always_comb begin
    pp_sel = 2'b00;
    if (busy) begin
      unique case ({q[0], qm1})
        2'b01:   pp_sel = 2'b01;
        2'b10:   pp_sel = 2'b10;
        default: pp_sel = 2'b00;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_mul_ctrl.sv
// Directed bench for booth_seq_mul_ctrl (N=16): handshake, latency, back-pressure,
// reset abort, pp_sel decode and products against hand-computed values.
module tb_booth_seq_mul_ctrl;

  localparam int N = 16;
`ifdef BOOTH_EARLY_TERM_EN
  localparam int LAT = -1;
`else
  localparam int LAT = 16;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic [1:0] pp_sel;

  booth_seq_mul_ctrl_if #(.N(N)) bus ();

  booth_seq_mul_ctrl #(.N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .busy   (busy),
    .pp_sel (pp_sel)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [15:0] m, input logic [15:0] r, input logic [31:0] exp_p,
                        input int exp_lat, input int hold);
    int          lat;
    logic [31:0] held;
    @(negedge clk);
    check("in_ready_idle", bus.in_ready, 1);
    bus.in_valid  = 1'b1;
    bus.M         = m;
    bus.R         = r;
    bus.out_ready = (hold == 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.M        = m ^ 16'hA5A5;
    bus.R        = ~r;
    check("in_ready_run", bus.in_ready, 0);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid_seen", bus.out_valid, 1);
    if (exp_lat >= 0) check("latency", lat, exp_lat);
    check("product", bus.P, exp_p);
    held = bus.P;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("p_stable", bus.P, held);
      check("valid_held", bus.out_valid, 1);
      check("in_ready_done", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("retired", bus.out_valid, 0);
    check("in_ready_after", bus.in_ready, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] rr;
    logic [15:0] rm;
    logic        prev;
    logic [1:0]  es;
    int          e;
    int          w;

    bus.in_valid  = 1'b0;
    bus.M         = '0;
    bus.R         = '0;
    bus.out_ready = 1'b1;
    #12;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_pp_sel", pp_sel, 0);
    check("rst_p", bus.P, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'd3, 16'd5, 32'h0000000F, LAT, 0);
    run_op(16'h8000, 16'h8000, 32'h40000000, LAT, 0);
    run_op(16'hFFFF, 16'h0001, 32'hFFFFFFFF, LAT, 0);
    run_op(16'h7FFF, 16'h8000, 32'hC0008000, LAT, 0);
    run_op(16'hFFF9, 16'd9, 32'hFFFFFFC1, LAT, 5);

    // Reset in the middle of RUN
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.M        = 16'd100;
    bus.R        = 16'd200;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("busy_mid", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_pp_sel", pp_sel, 0);
    check("abort_p", bus.P, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'd2, 16'hFFFD, 32'hFFFFFFFA, LAT, 0);

    // pp_sel trace, reference decode taken from the multiplier bits
    rr = 16'b0110;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.M        = 16'd1;
    bus.R        = rr;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    prev = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!busy) break;
      unique case ({rr[k], prev})
        2'b01:   es = 2'b01;
        2'b10:   es = 2'b10;
        default: es = 2'b00;
      endcase
      check("pp_sel", pp_sel, es);
      prev = rr[k];
      @(posedge clk); #1;
    end
    w = 0;
    while (!bus.out_valid && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    check("pp_trace_valid", bus.out_valid, 1);
    check("pp_trace_product", bus.P, 32'h00000006);
    @(posedge clk); #1;
    check("pp_trace_retired", bus.out_valid, 0);

`ifdef BOOTH_EARLY_TERM_EN
    run_op(16'd1234, 16'h0000, 32'h00000000, 1, 0);
    run_op(16'd1234, 16'h0001, 32'h000004D2, 2, 0);
    run_op(16'd1234, 16'hFFFF, 32'hFFFFFB2E, 1, 0);
    for (int i = 0; i < 500; i++) begin
`else
    for (int i = 0; i < 16; i++) begin
`endif
      rm = 16'($urandom);
      rr = 16'($urandom);
      e  = int'($signed(rm)) * int'($signed(rr));
      run_op(rm, rr, 32'(e), LAT, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
